// File: rtl/fas_pkg.sv
// Shared constants and types for the FAS frame scheduler and its peak scanner.
package fas_pkg;

    localparam int NPT    = 16;
    localparam int DW     = 16;
    localparam int BW     = 32;
    localparam int FREQ_W = $clog2(NPT);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } bin_t;

    typedef enum logic [1:0] {
        ANA_IDLE   = 2'd0,
        ANA_SCAN   = 2'd1,
        ANA_REPORT = 2'd2
    } ana_state_e;

    // re^2 + im^2 peaks at 2*2^30, so a 32-bit unsigned sum cannot overflow.
    function automatic logic [31:0] mag_sq(input bin_t b);
        logic signed [31:0] re_w;
        logic signed [31:0] im_w;
        re_w = 32'(b.re);
        im_w = 32'(b.im);
        return $unsigned(re_w * re_w) + $unsigned(im_w * im_w);
    endfunction

endpackage

// File: rtl/fas_peak_scan.sv
// Magnitude-squared argmax over one bin per cycle; first restarts, last marks the final bin.
module fas_peak_scan
    import fas_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic [BW-1:0]     bin_i,
    output logic [FREQ_W-1:0] peak_idx_o,
    output logic              peak_valid_o
);

    logic [31:0]       mag;
    logic              take;
    logic [FREQ_W-1:0] cur_idx;
    logic [FREQ_W-1:0] idx_q, idx_d;
    logic [FREQ_W-1:0] peak_idx_q, peak_idx_d;
    logic [31:0]       peak_mag_q, peak_mag_d;

    always_comb begin
        mag        = mag_sq(bin_t'(bin_i));
        cur_idx    = first_i ? '0 : idx_q;
        // Strictly greater: ties keep the lower bin index.
        take       = first_i || (mag > peak_mag_q);
        idx_d      = idx_q;
        peak_idx_d = peak_idx_q;
        peak_mag_d = peak_mag_q;
        if (en_i) begin
            idx_d = cur_idx + 1'b1;
            if (take) begin
                peak_idx_d = cur_idx;
                peak_mag_d = mag;
            end
        end
        peak_idx_o   = (en_i && take) ? cur_idx : peak_idx_q;
        peak_valid_o = en_i && last_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            peak_idx_q <= '0;
            peak_mag_q <= '0;
        end else begin
            idx_q      <= idx_d;
            peak_idx_q <= peak_idx_d;
            peak_mag_q <= peak_mag_d;
        end
    end

endmodule

// File: rtl/fas_fft_sched.sv
// Packs FIR samples into 16-point frames, launches the FFT engine, captures its
// results and reports the peak bin after a 16-cycle scan.
module fas_fft_sched
    import fas_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                fir_valid,
    input  logic [DW-1:0]       fir_d,
    input  logic                fft_busy,
    output logic                fft_start,
    output logic [NPT*DW-1:0]   fft_frame,
    input  logic                fft_done,
    input  logic [NPT*BW-1:0]   fft_res,
    output logic                fft_valid,
    output logic [NPT*BW-1:0]   fft_out,
    output logic                done,
    output logic [FREQ_W-1:0]   freq,
    output logic                ovf
);

    logic [FREQ_W-1:0]  cnt_q, cnt_d;
    logic [NPT*DW-1:0]  coll_q, coll_d;
    logic [NPT*DW-1:0]  pend_q, pend_d;
    logic               pend_v_q, pend_v_d;
    logic               ovf_q, ovf_d;
    logic               frame_last;

    logic [NPT*BW-1:0]  fft_out_q, fft_out_d;
    logic               fft_valid_q, fft_valid_d;
    ana_state_e         state_q, state_d;
    logic [FREQ_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               scan_en;
    logic [BW-1:0]      scan_bin;
    logic [FREQ_W-1:0]  peak_idx;
    logic               peak_valid;

    // Collect and pending register. A frame completing while the pending one
    // launches in the same cycle replaces it without loss.
    always_comb begin
        coll_d     = coll_q;
        cnt_d      = cnt_q;
        frame_last = fir_valid && (cnt_q == FREQ_W'(NPT - 1));
        if (fir_valid) begin
            coll_d[int'(cnt_q)*DW +: DW] = fir_d;
            cnt_d = cnt_q + 1'b1;
        end

        fft_start = pend_v_q & ~fft_busy;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q & ~fft_start;
        ovf_d     = ovf_q;
        if (frame_last) begin
            if (!pend_v_q || fft_start) begin
                pend_d   = coll_d;
                pend_v_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        fft_out_d   = fft_done ? fft_res : fft_out_q;
        fft_valid_d = fft_done;
        state_d     = state_q;
        scan_cnt_d  = scan_cnt_q;
        freq_d      = freq_q;
        scan_en     = (state_q == ANA_SCAN);
        scan_bin    = fft_out_q[int'(scan_cnt_q)*BW +: BW];

        case (state_q)
            ANA_IDLE: ;
            ANA_SCAN: begin
                scan_cnt_d = scan_cnt_q + 1'b1;
                if (scan_cnt_q == FREQ_W'(NPT - 1)) state_d = ANA_REPORT;
            end
            ANA_REPORT: state_d = ANA_IDLE;
            default:    state_d = ANA_IDLE;
        endcase

        // A new result set abandons the running scan; its peak is never reported.
        if (peak_valid && !fft_done) freq_d = peak_idx;
        if (fft_done) begin
            state_d    = ANA_SCAN;
            scan_cnt_d = '0;
        end
    end

    fas_peak_scan u_peak_scan (
        .clk          (clk),
        .rst          (rst),
        .en_i         (scan_en),
        .first_i      (scan_en && (scan_cnt_q == '0)),
        .last_i       (scan_cnt_q == FREQ_W'(NPT - 1)),
        .bin_i        (scan_bin),
        .peak_idx_o   (peak_idx),
        .peak_valid_o (peak_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            coll_q      <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            ovf_q       <= 1'b0;
            fft_out_q   <= '0;
            fft_valid_q <= 1'b0;
            state_q     <= ANA_IDLE;
            scan_cnt_q  <= '0;
            freq_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            coll_q      <= coll_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            ovf_q       <= ovf_d;
            fft_out_q   <= fft_out_d;
            fft_valid_q <= fft_valid_d;
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            freq_q      <= freq_d;
        end
    end

    assign fft_frame = pend_q;
    assign fft_valid = fft_valid_q;
    assign fft_out   = fft_out_q;
    assign done      = (state_q == ANA_REPORT);
    assign freq      = freq_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fas_fft_sched.sv
// Bench for fas_fft_sched: frame/issue and spectrum/peak reference model with queued expectations.
module tb_fas_fft_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fir_valid = 1'b0;
    logic [15:0]  fir_d = '0;
    logic         fft_busy = 1'b0;
    logic         fft_start;
    logic [255:0] fft_frame;
    logic         fft_done = 1'b0;
    logic [511:0] fft_res = '0;
    logic         fft_valid;
    logic [511:0] fft_out;
    logic         done;
    logic [3:0]   freq;
    logic         ovf;

    fas_fft_sched dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .fft_busy  (fft_busy),
        .fft_start (fft_start),
        .fft_frame (fft_frame),
        .fft_done  (fft_done),
        .fft_res   (fft_res),
        .fft_valid (fft_valid),
        .fft_out   (fft_out),
        .done      (done),
        .freq      (freq),
        .ovf       (ovf)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    typedef struct {
        int         at;
        logic [3:0] f;
    } done_t;

    logic [15:0]  samp_q[$];
    logic [255:0] exp_q[$];
    done_t        done_q[$];
    logic         m_ovf   = 1'b0;
    logic [511:0] m_out   = '0;
    logic [3:0]   m_freq  = '0;
    int           valid_at = -1;
    int           cyc = 0;

    function automatic logic [3:0] argmax(input logic [511:0] r);
        longint best;
        longint m;
        logic [3:0] bi;
        logic signed [15:0] re;
        logic signed [15:0] im;
        best = -1;
        bi = '0;
        for (int k = 0; k < 16; k++) begin
            re = r[32*k+16 +: 16];
            im = r[32*k +: 16];
            m = longint'(re) * longint'(re) + longint'(im) * longint'(im);
            if (m > best) begin
                best = m;
                bi = 4'(k);
            end
        end
        return bi;
    endfunction

    always @(posedge clk) begin
        logic [255:0] frame;
        cyc++;
        if (rst) begin
            samp_q.delete();
            exp_q.delete();
            done_q.delete();
            m_ovf = 1'b0;
            m_out = '0;
            m_freq = '0;
            valid_at = -1;
        end else begin
            if (fir_valid) begin
                samp_q.push_back(fir_d);
                if (samp_q.size() == 16) begin
                    for (int i = 0; i < 16; i++) frame[16*i +: 16] = samp_q[i];
                    samp_q.delete();
                    if (exp_q.size() == 0) exp_q.push_back(frame);
                    else m_ovf = 1'b1;
                end
            end
            if (fft_done) begin
                valid_at = cyc;
                m_out = fft_res;
                done_q.delete();
                done_q.push_back('{cyc + 16, argmax(fft_res)});
            end
        end
    end

    // Monitor / scoreboard
    logic         exp_start;
    logic         exp_done;
    logic [255:0] exp_frame;
    done_t        d_front;

    always @(negedge clk) begin
        exp_start = (exp_q.size() != 0) && !fft_busy;
        chk("fft_start", fft_start, exp_start);
        if (exp_start) begin
            exp_frame = exp_q.pop_front();
            chk("fft_frame", fft_frame, exp_frame);
        end
        chk("fft_valid", fft_valid, cyc == valid_at);
        chk("fft_out", fft_out, m_out);
        exp_done = 1'b0;
        if (done_q.size() != 0 && done_q[0].at == cyc) begin
            d_front = done_q.pop_front();
            exp_done = 1'b1;
            m_freq = d_front.f;
        end
        chk("done", done, exp_done);
        chk("freq", freq, m_freq);
        chk("ovf", ovf, m_ovf);
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [15:0] d);
        fir_valid = 1'b1;
        fir_d = d;
        step();
        fir_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [511:0] r);
        fft_done = 1'b1;
        fft_res = r;
        step();
        fft_done = 1'b0;
    endtask

    function automatic logic [511:0] rand_res();
        logic [511:0] r;
        logic [31:0] pick[4];
        int mode;
        pick[0] = 32'h0000_0000;
        pick[1] = 32'h0001_0000;
        pick[2] = 32'h0000_FFFF;
        pick[3] = 32'h8000_8000;
        mode = $urandom_range(0, 2);
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (mode == 0) r[32*k +: 32] = $urandom;
            else if (mode == 1) r[32*k +: 32] = pick[$urandom_range(0, 3)];
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] r;
        idle(3);
        rst = 1'b0;
        step();

        // Single frame
        for (int i = 1; i <= 16; i++) send(16'(i << 8));
        chk("start_latency", fft_start, 1'b1);
        chk("frame_slot0", fft_frame[15:0], 16'h0100);
        chk("frame_slot15", fft_frame[255:240], 16'h1000);
        send(16'h1100);
        idle(3);

        // Busy hold-off
        fft_busy = 1'b1;
        for (int i = 0; i < 15; i++) send(16'($urandom));
        idle(40);
        fft_busy = 1'b0;
        #1;
        chk("holdoff_start", fft_start, 1'b1);
        chk("holdoff_ovf", ovf, 1'b0);
        step();
        idle(3);

        // Overflow: release busy in the cycle the third frame completes
        fft_busy = 1'b1;
        for (int i = 0; i < 16; i++) send(16'($urandom));
        chk("ovf_after_1", ovf, 1'b0);
        for (int i = 0; i < 16; i++) send(16'($urandom));
        chk("ovf_after_2", ovf, 1'b1);
        for (int i = 0; i < 15; i++) send(16'($urandom));
        fft_busy = 1'b0;
        send(16'($urandom));
        idle(4);

        // Peak and tie
        r = '0;
        r[5*32 +: 32] = {16'h0300, 16'h0400};
        r[9*32 +: 32] = {16'h0400, 16'h0300};
        pulse_done(r);
        chk("peak_fft_valid", fft_valid, 1'b1);
        idle(16);
        chk("peak_done", done, 1'b1);
        chk("peak_freq", freq, 4'd5);
        idle(3);

        // Restart
        r = '0;
        r[3*32 +: 32] = {16'h0100, 16'h0000};
        pulse_done(r);
        idle(7);
        r = '0;
        r[12*32 +: 32] = {16'h0000, 16'hF000};
        r[2*32 +: 32] = {16'h0010, 16'h0010};
        pulse_done(r);
        idle(16);
        chk("restart_done", done, 1'b1);
        chk("restart_freq", freq, 4'd12);
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            fir_valid = ($urandom_range(0, 3) != 0);
            fir_d = 16'($urandom);
            if ($urandom_range(0, 15) == 0) fft_busy = ~fft_busy;
            fft_done = ($urandom_range(0, 19) == 0);
            if (fft_done) fft_res = rand_res();
            step();
        end
        fir_valid = 1'b0;
        fft_done = 1'b0;
        fft_busy = 1'b0;
        idle(40);

        // Reset mid-frame
        for (int i = 0; i < 10; i++) send(16'hDEAD);
        rst = 1'b1;
        step();
        chk("rst_freq", freq, 4'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send(16'h2000 + 16'(i));
        chk("rst_start", fft_start, 1'b1);
        chk("rst_frame_slot0", fft_frame[15:0], 16'h2000);
        idle(5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
